// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit signal bundle: D/E/M/W stage fields in, stall/flush/forward controls out.
// The master modport is the pipeline side and the slave modport is the hazard unit side.
interface hazard_scoreboard_if #(
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0] raddr1D;
    logic [AW-1:0] raddr2D;
    logic [AW-1:0] waddrD;
    logic          reg_wrD;
    logic          lu_startD;

    logic [AW-1:0] raddr1E;
    logic [AW-1:0] raddr2E;
    logic [AW-1:0] waddrE;
    logic          reg_wrE;
    logic [1:0]    wb_selE;
    logic          lu_startE;
    logic          br_takenE;

    logic [AW-1:0] waddrM;
    logic [AW-1:0] waddrW;
    logic          reg_wrM;
    logic          reg_wrW;

    logic          StallF;
    logic          StallD;
    logic          FlushD;
    logic          FlushE;
    logic [1:0]    forwardAE;
    logic [1:0]    forwardBE;
    logic          lu_busy;

    modport master (
        output raddr1D, raddr2D, waddrD, reg_wrD, lu_startD,
        output raddr1E, raddr2E, waddrE, reg_wrE, wb_selE, lu_startE, br_takenE,
        output waddrM, waddrW, reg_wrM, reg_wrW,
        input  StallF, StallD, FlushD, FlushE, forwardAE, forwardBE, lu_busy
    );

    modport slave (
        input  raddr1D, raddr2D, waddrD, reg_wrD, lu_startD,
        input  raddr1E, raddr2E, waddrE, reg_wrE, wb_selE, lu_startE, br_takenE,
        input  waddrM, waddrW, reg_wrM, reg_wrW,
        output StallF, StallD, FlushD, FlushE, forwardAE, forwardBE, lu_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and an optional
// long-latency (mul/div) scoreboard enabled by defining HAZARD_LU_SCOREBOARD_EN.
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int LU_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave hif
);
    localparam int AW = $clog2(NREG);

    logic load_stall;
    logic sb_stall;
    logic stall;

    // M result wins over W; register 0 always reads the register file.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic [AW-1:0] wa_m,
        input logic          wr_m,
        input logic [AW-1:0] wa_w,
        input logic          wr_w
    );
        logic [1:0] sel;
        sel = 2'b01;
        if (src == '0)
            sel = 2'b01;
        else if (wr_m && (wa_m == src))
            sel = 2'b00;
        else if (wr_w && (wa_w == src))
            sel = 2'b10;
        return sel;
    endfunction

    assign hif.forwardAE = fwd_sel(hif.raddr1E, hif.waddrM, hif.reg_wrM, hif.waddrW, hif.reg_wrW);
    assign hif.forwardBE = fwd_sel(hif.raddr2E, hif.waddrM, hif.reg_wrM, hif.waddrW, hif.reg_wrW);

    assign load_stall = (hif.wb_selE == 2'b10) && hif.reg_wrE && (hif.waddrE != '0) &&
                        ((hif.raddr1D == hif.waddrE) || (hif.raddr2D == hif.waddrE));

`ifdef HAZARD_LU_SCOREBOARD_EN
    localparam int            CW       = $clog2(LU_LAT + 1);
    localparam logic [CW-1:0] LU_LAT_C = CW'(LU_LAT);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [AW-1:0] lu_rd;
    logic [AW-1:0] lu_rd_next;
    logic          lu_busy_q;
    logic          busy;
    logic          issue;
    logic          hit_issue;
    logic          hit_busy;
    logic          unused_sb;

    assign unused_sb = ^{1'b0};
    assign issue     = hif.lu_startE & ~hif.br_takenE;
    assign busy      = (cnt != '0);

    // An issue in the cycle cnt reaches 1 reloads directly, so busy never drops between ops.
    always_comb begin
        cnt_next   = cnt;
        lu_rd_next = lu_rd;
        if (issue) begin
            cnt_next   = LU_LAT_C;
            lu_rd_next = hif.waddrE;
        end else if (busy) begin
            cnt_next = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            lu_rd     <= '0;
            lu_busy_q <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            lu_rd     <= lu_rd_next;
            lu_busy_q <= (cnt_next != '0);
        end
    end

    assign hit_issue = issue && (hif.waddrE != '0) &&
                       ((hif.raddr1D == hif.waddrE) || (hif.raddr2D == hif.waddrE) ||
                        (hif.reg_wrD && (hif.waddrD == hif.waddrE)));
    assign hit_busy  = busy && (lu_rd != '0) &&
                       ((hif.raddr1D == lu_rd) || (hif.raddr2D == lu_rd) ||
                        (hif.reg_wrD && (hif.waddrD == lu_rd)));
    assign sb_stall  = hit_issue | hit_busy | (hif.lu_startD & (busy | hif.lu_startE));
    assign hif.lu_busy = lu_busy_q;
`else
    logic unused_sb;

    assign unused_sb   = ^{clk, hif.lu_startD, hif.lu_startE, hif.waddrD, hif.reg_wrD};
    assign sb_stall    = 1'b0;
    assign hif.lu_busy = 1'b0;
`endif

    assign stall = load_stall | sb_stall;

    // Branch overrides stall; reset masks the hold/bubble-D controls but not FlushE.
    always_comb begin
        hif.StallF = stall;
        hif.StallD = stall;
        hif.FlushE = stall;
        hif.FlushD = 1'b0;
        if (hif.br_takenE) begin
            hif.StallF = 1'b0;
            hif.StallD = 1'b0;
            hif.FlushD = 1'b1;
            hif.FlushE = 1'b1;
        end
        if (rst) begin
            hif.StallF = 1'b0;
            hif.StallD = 1'b0;
            hif.FlushD = 1'b0;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (NREG=32, LU_LAT=4); scoreboard
// scenarios run when HAZARD_LU_SCOREBOARD_EN is defined, disabled-behaviour checks otherwise.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_scoreboard_if #(.NREG(32)) hif ();

    hazard_scoreboard #(.NREG(32), .LU_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        hif.raddr1D = '0; hif.raddr2D = '0; hif.waddrD = '0; hif.reg_wrD = 1'b0; hif.lu_startD = 1'b0;
        hif.raddr1E = '0; hif.raddr2E = '0; hif.waddrE = '0; hif.reg_wrE = 1'b0;
        hif.wb_selE = 2'b00; hif.lu_startE = 1'b0; hif.br_takenE = 1'b0;
        hif.waddrM = '0; hif.waddrW = '0; hif.reg_wrM = 1'b0; hif.reg_wrW = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        hif.wb_selE = 2'b10; hif.reg_wrE = 1'b1; hif.waddrE = 5'd7; hif.raddr2D = 5'd7;
        #2;
        total++; if (hif.lu_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", hif.lu_busy); end
        total++; if (hif.StallF !== 1'b0) begin bad++; $display("FAIL rst_stallf: got %b want 0", hif.StallF); end
        total++; if (hif.StallD !== 1'b0) begin bad++; $display("FAIL rst_stalld: got %b want 0", hif.StallD); end
        total++; if (hif.FlushD !== 1'b0) begin bad++; $display("FAIL rst_flushd: got %b want 0", hif.FlushD); end
        total++; if (hif.FlushE !== 1'b1) begin bad++; $display("FAIL rst_flushe: got %b want 1", hif.FlushE); end
        step();
        rst = 1'b0;
        idle();
        #2;
        total++; if (hif.StallF !== 1'b0) begin bad++; $display("FAIL rst_idle_stallf: got %b want 0", hif.StallF); end
        total++; if (hif.lu_busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy: got %b want 0", hif.lu_busy); end
        step();
    endtask

    task automatic test_forward();
        idle();
        hif.waddrM = 5'd5; hif.reg_wrM = 1'b1; hif.waddrW = 5'd5; hif.reg_wrW = 1'b1;
        hif.raddr1E = 5'd5; hif.raddr2E = 5'd5;
        #2;
        total++; if (hif.forwardAE !== 2'b00) begin bad++; $display("FAIL fwd_a_mpri: got %b want 00", hif.forwardAE); end
        total++; if (hif.forwardBE !== 2'b00) begin bad++; $display("FAIL fwd_b_mpri: got %b want 00", hif.forwardBE); end
        hif.raddr1E = 5'd0; hif.waddrM = 5'd0; hif.waddrW = 5'd0;
        #2;
        total++; if (hif.forwardAE !== 2'b01) begin bad++; $display("FAIL fwd_a_zero: got %b want 01", hif.forwardAE); end
        hif.waddrM = 5'd5; hif.reg_wrM = 1'b0; hif.waddrW = 5'd5; hif.raddr1E = 5'd5;
        #2;
        total++; if (hif.forwardAE !== 2'b10) begin bad++; $display("FAIL fwd_a_w: got %b want 10", hif.forwardAE); end
        hif.reg_wrM = 1'b1; hif.waddrW = 5'd6; hif.raddr2E = 5'd6;
        #2;
        total++; if (hif.forwardAE !== 2'b00) begin bad++; $display("FAIL fwd_a_m: got %b want 00", hif.forwardAE); end
        total++; if (hif.forwardBE !== 2'b10) begin bad++; $display("FAIL fwd_b_w: got %b want 10", hif.forwardBE); end
        hif.raddr1E = 5'd3; hif.reg_wrW = 1'b0;
        #2;
        total++; if (hif.forwardAE !== 2'b01) begin bad++; $display("FAIL fwd_a_none: got %b want 01", hif.forwardAE); end
        total++; if (hif.forwardBE !== 2'b01) begin bad++; $display("FAIL fwd_b_wroff: got %b want 01", hif.forwardBE); end
        step();
    endtask

    task automatic test_load_stall();
        idle();
        hif.wb_selE = 2'b10; hif.reg_wrE = 1'b1; hif.waddrE = 5'd7; hif.raddr2D = 5'd7;
        #2;
        total++; if (hif.StallF !== 1'b1) begin bad++; $display("FAIL ld_stallf: got %b want 1", hif.StallF); end
        total++; if (hif.StallD !== 1'b1) begin bad++; $display("FAIL ld_stalld: got %b want 1", hif.StallD); end
        total++; if (hif.FlushE !== 1'b1) begin bad++; $display("FAIL ld_flushe: got %b want 1", hif.FlushE); end
        total++; if (hif.FlushD !== 1'b0) begin bad++; $display("FAIL ld_flushd: got %b want 0", hif.FlushD); end
        step();
        // load has moved on; E now holds the bubble
        idle();
        hif.raddr2D = 5'd7;
        #2;
        total++; if (hif.StallF !== 1'b0) begin bad++; $display("FAIL ld_release: got %b want 0", hif.StallF); end
        step();
        idle();
        hif.wb_selE = 2'b10; hif.reg_wrE = 1'b1; hif.waddrE = 5'd0; hif.raddr2D = 5'd0;
        #2;
        total++; if (hif.StallF !== 1'b0) begin bad++; $display("FAIL ld_r0: got %b want 0", hif.StallF); end
        hif.waddrE = 5'd8; hif.raddr1D = 5'd8; hif.wb_selE = 2'b00;
        #2;
        total++; if (hif.StallD !== 1'b0) begin bad++; $display("FAIL ld_notload: got %b want 0", hif.StallD); end
        hif.wb_selE = 2'b10; hif.reg_wrE = 1'b0;
        #2;
        total++; if (hif.FlushE !== 1'b0) begin bad++; $display("FAIL ld_nowr: got %b want 0", hif.FlushE); end
        step();
    endtask

    task automatic test_branch();
        idle();
        hif.wb_selE = 2'b10; hif.reg_wrE = 1'b1; hif.waddrE = 5'd7; hif.raddr1D = 5'd7;
        hif.br_takenE = 1'b1; hif.lu_startE = 1'b1;
        #2;
        total++; if (hif.StallF !== 1'b0) begin bad++; $display("FAIL br_stallf: got %b want 0", hif.StallF); end
        total++; if (hif.StallD !== 1'b0) begin bad++; $display("FAIL br_stalld: got %b want 0", hif.StallD); end
        total++; if (hif.FlushD !== 1'b1) begin bad++; $display("FAIL br_flushd: got %b want 1", hif.FlushD); end
        total++; if (hif.FlushE !== 1'b1) begin bad++; $display("FAIL br_flushe: got %b want 1", hif.FlushE); end
        step();
        idle();
        hif.raddr1D = 5'd7;
        #2;
        total++; if (hif.lu_busy !== 1'b0) begin bad++; $display("FAIL br_noissue_busy: got %b want 0", hif.lu_busy); end
        total++; if (hif.StallD !== 1'b0) begin bad++; $display("FAIL br_noissue_stall: got %b want 0", hif.StallD); end
        step();
    endtask

`ifdef HAZARD_LU_SCOREBOARD_EN
    task automatic test_lu_issue();
        idle();
        hif.lu_startE = 1'b1; hif.reg_wrE = 1'b1; hif.waddrE = 5'd9; hif.raddr1D = 5'd9;
        #2;
        total++; if (hif.StallF !== 1'b1) begin bad++; $display("FAIL lu_t_stall: got %b want 1", hif.StallF); end
        total++; if (hif.lu_busy !== 1'b0) begin bad++; $display("FAIL lu_t_busy: got %b want 0", hif.lu_busy); end
        step();
        idle();
        hif.raddr1D = 5'd9;
        for (int i = 1; i <= 4; i++) begin
            #2;
            total++; if (hif.StallD !== 1'b1) begin bad++; $display("FAIL lu_hold_stall[t+%0d]: got %b want 1", i, hif.StallD); end
            total++; if (hif.lu_busy !== 1'b1) begin bad++; $display("FAIL lu_hold_busy[t+%0d]: got %b want 1", i, hif.lu_busy); end
            if (i == 2) begin
                hif.raddr1D = 5'd3;
                #1;
                total++; if (hif.StallD !== 1'b0) begin bad++; $display("FAIL lu_unrelated: got %b want 0", hif.StallD); end
                hif.raddr1D = 5'd9;
            end
            step();
        end
        #2;
        total++; if (hif.StallD !== 1'b0) begin bad++; $display("FAIL lu_release_stall: got %b want 0", hif.StallD); end
        total++; if (hif.lu_busy !== 1'b0) begin bad++; $display("FAIL lu_release_busy: got %b want 0", hif.lu_busy); end
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        hif.lu_startE = 1'b1; hif.waddrE = 5'd9;
        step();
        idle();
        step();
        step();
        // cnt is now 2
        rst = 1'b1;
        hif.raddr1D = 5'd9;
        #2;
        total++; if (hif.StallF !== 1'b0) begin bad++; $display("FAIL rmid_inrst_stall: got %b want 0", hif.StallF); end
        step();
        rst = 1'b0;
        #2;
        total++; if (hif.lu_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", hif.lu_busy); end
        total++; if (hif.StallD !== 1'b0) begin bad++; $display("FAIL rmid_oldrd: got %b want 0", hif.StallD); end
        step();
    endtask

    task automatic test_back_to_back();
        // structural: lu_startD waits for the unit to drain
        idle();
        hif.lu_startE = 1'b1; hif.waddrE = 5'd10; hif.lu_startD = 1'b1;
        #2;
        total++; if (hif.StallF !== 1'b1) begin bad++; $display("FAIL st_issue_cycle: got %b want 1", hif.StallF); end
        step();
        idle();
        hif.lu_startD = 1'b1; hif.raddr1D = 5'd1; hif.raddr2D = 5'd2;
        for (int i = 1; i <= 4; i++) begin
            #2;
            total++; if (hif.StallD !== 1'b1) begin bad++; $display("FAIL st_busy[t+%0d]: got %b want 1", i, hif.StallD); end
            step();
        end
        #2;
        total++; if (hif.StallD !== 1'b0) begin bad++; $display("FAIL st_release: got %b want 0", hif.StallD); end
        step();
        // destination match against lu_rd
        idle();
        hif.lu_startE = 1'b1; hif.waddrE = 5'd13;
        step();
        idle();
        hif.reg_wrD = 1'b1; hif.waddrD = 5'd13;
        #2;
        total++; if (hif.StallF !== 1'b1) begin bad++; $display("FAIL waw_stall: got %b want 1", hif.StallF); end
        hif.reg_wrD = 1'b0;
        #1;
        total++; if (hif.StallF !== 1'b0) begin bad++; $display("FAIL waw_nowr: got %b want 0", hif.StallF); end
        idle();
        for (int i = 0; i < 4; i++) step();
        // reissue at cnt=1 keeps busy continuous
        idle();
        hif.lu_startE = 1'b1; hif.waddrE = 5'd11;
        step();
        for (int i = 1; i <= 8; i++) begin
            idle();
            if (i == 4) begin
                hif.lu_startE = 1'b1; hif.waddrE = 5'd12;
            end
            #2;
            total++; if (hif.lu_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy[t+%0d]: got %b want 1", i, hif.lu_busy); end
            step();
        end
        idle();
        #2;
        total++; if (hif.lu_busy !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", hif.lu_busy); end
        step();
    endtask
`else
    task automatic test_lu_disabled();
        idle();
        hif.lu_startE = 1'b1; hif.lu_startD = 1'b1; hif.reg_wrE = 1'b1; hif.waddrE = 5'd9; hif.raddr1D = 5'd9;
        #2;
        total++; if (hif.StallF !== 1'b0) begin bad++; $display("FAIL dis_stall: got %b want 0", hif.StallF); end
        step();
        idle();
        hif.raddr1D = 5'd9; hif.lu_startD = 1'b1;
        #2;
        total++; if (hif.lu_busy !== 1'b0) begin bad++; $display("FAIL dis_busy: got %b want 0", hif.lu_busy); end
        total++; if (hif.StallD !== 1'b0) begin bad++; $display("FAIL dis_nohold: got %b want 0", hif.StallD); end
        step();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_forward();
        test_load_stall();
        test_branch();
`ifdef HAZARD_LU_SCOREBOARD_EN
        test_lu_issue();
        test_reset_mid();
        test_back_to_back();
`else
        test_lu_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREG, 32, architectural register count; AW = $clog2(NREG).
- LU_LAT, 4, long-latency unit (mul/div) cycles, >= 1; CW = $clog2(LU_LAT+1).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, reset (one clock; synchronous, active-high).
- raddr1D, raddr2D, in, AW, D-stage sources.
- waddrD, in, AW, D-stage destination.
- reg_wrD, in, 1, D-stage register write.
- lu_startD, in, 1, D-stage is a long-latency op.
- raddr1E, raddr2E, waddrE, in, AW, E-stage sources and destination.
- reg_wrE, in, 1, E-stage register write.
- wb_selE, in, 2, E-stage writeback select; 2'b10 = load.
- lu_startE, in, 1, E-stage issues a long-latency op.
- br_takenE, in, 1, branch/jump taken in E.
- waddrM, waddrW, in, AW, M and W destinations.
- reg_wrM, reg_wrW, in, 1, M and W write enables.
- StallF, StallD, out, 1, hold PC / hold IF-ID register.
- FlushD, FlushE, out, 1, bubble IF-ID / ID-EX register.
- forwardAE, forwardBE, out, 2, operand select.
- lu_busy, out, 1, long-latency op outstanding.

Function
REQ-003 Forwarding encoding SHALL be: 2'b00 = M result, 2'b10 = W result, 2'b01 = register file.
- M has priority over W.
- A source equal to 0 SHALL always select 2'b01.
REQ-004 loadStall SHALL be wb_selE==2'b10 & reg_wrE & waddrE!=0 & (raddr1D==waddrE | raddr2D==waddrE).
REQ-005 The scoreboard SHALL hold busy (cnt!=0), a down-counter cnt[CW-1:0], and a tag lu_rd[AW-1:0].
REQ-006 Issue SHALL occur on lu_startE & !br_takenE.
- Next cycle: cnt=LU_LAT, lu_rd=waddrE.
- Otherwise, if cnt!=0, cnt SHALL decrement by 1 per cycle, with no wrap below 0.
REQ-007 sbStall SHALL be asserted when any of the following holds:
- Issue active and a nonzero D source or D destination (reg_wrD) equals waddrE.
- busy, lu_rd!=0, and a D source or D destination (reg_wrD) equals lu_rd.
- lu_startD & (busy | lu_startE): structural conflict.
REQ-008 With stall = loadStall | sbStall:
- If br_takenE: StallF=StallD=0 and FlushD=FlushE=1 (branch overrides stall).
- Otherwise: StallF=StallD=stall, FlushE=stall, FlushD=0.
REQ-009 lu_busy SHALL equal cnt!=0, registered with no combinational path from inputs.
REQ-010 A D instruction hit by sbStall at an issue in cycle t SHALL stay stalled through cycle t+LU_LAT and be released in cycle t+LU_LAT+1.
REQ-011 A new issue in the same cycle that cnt reaches 1 SHALL reload cnt=LU_LAT with no idle cycle.
REQ-012 All stall, flush and forward outputs SHALL be combinational from inputs and scoreboard state; latency 0.

Reset
REQ-013 rst SHALL clear cnt to 0 and lu_rd to 0 on the next clk edge, including mid-operation. After reset lu_busy=0.
REQ-014 While rst is high, state outputs SHALL read: lu_busy=0, StallF=StallD=FlushD=0. FlushE and the forwarding outputs follow the input equations.

Configuration
REQ-015 With macro HAZARD_LU_SCOREBOARD_EN defined, REQ-005 to REQ-011 SHALL be implemented as specified.
REQ-016 Without HAZARD_LU_SCOREBOARD_EN:
- No scoreboard flops are instantiated.
- sbStall=0 and lu_busy=0.
- lu_startD and lu_startE are ignored.
- Forwarding, loadStall and branch flush are unchanged.

Verification (LU_LAT=4, macro defined)
REQ-017 E: waddrM=5, reg_wrM=1, waddrW=5, reg_wrW=1, raddr1E=5 -> forwardAE=00. Same with raddr1E=0 -> forwardAE=01.
REQ-018 E load (wb_selE=10, waddrE=7, reg_wrE=1), D raddr2D=7 -> StallF=StallD=FlushE=1 for 1 cycle. Same with waddrE=0 -> no stall.
REQ-019 Issue in cycle t with waddrE=9, D raddr1D=9 -> stall in cycles t..t+4; lu_busy=1 in t+1..t+4; release in t+5.
REQ-020 br_takenE=1 coincident with loadStall -> StallF=StallD=0, FlushD=FlushE=1; no issue recorded.
REQ-021 rst pulse at cnt=2 -> next cycle lu_busy=0; a D read of the old lu_rd does not stall.
REQ-022 lu_startD=1 while busy -> stall until cnt=0. Back-to-back issue at cnt=1 -> lu_busy stays 1 continuously.
